dijkstra_sequencer: RTL and testbench

Control FSM for one single-source shortest-path run. Owns the distance and visited registers, drives them into the MinHeap min-finder, and waits for its ready flag. For each selected node it scans one adjacency-matrix row through a 1-cycle-latency read port and relaxes distances. Sits between the host start/done interface, the adjacency memory and the MinHeap instance.

---
 rtl/dijkstra_sequencer_if.sv | 33 +++
 rtl/dijkstra_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_dijkstra_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dijkstra_sequencer_if.sv
// dijkstra_sequencer_if: handshake and memory/min-finder bus of the
// shortest-path sequencer. The master view is the sequencer itself; the
// slave view is the surrounding host, adjacency memory and min-finder.
interface dijkstra_sequencer_if #(
    parameter int INDEX_WIDTH = 3,
    parameter int VALUE_WIDTH = 8
);
    logic                   start;
    logic [INDEX_WIDTH-1:0] source;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic                   adj_rd_en;
    logic [INDEX_WIDTH-1:0] adj_row;
    logic [INDEX_WIDTH-1:0] adj_col;
    logic [VALUE_WIDTH-1:0] adj_weight;
    logic                   heap_set_en;
    logic                   heap_min_ready;
    logic [INDEX_WIDTH-1:0] heap_min_index;
    logic [VALUE_WIDTH-1:0] heap_min_value;

    modport master (
        input  start, source, adj_weight,
        input  heap_min_ready, heap_min_index, heap_min_value,
        output busy, done, err, adj_rd_en, adj_row, adj_col, heap_set_en
    );

    modport slave (
        output start, source, adj_weight,
        output heap_min_ready, heap_min_index, heap_min_value,
        input  busy, done, err, adj_rd_en, adj_row, adj_col, heap_set_en
    );
endinterface

// File: rtl/dijkstra_sequencer.sv
// dijkstra_sequencer: control FSM for one single-source shortest-path run.
// Owns the distance and visited registers, re-arms the external min-finder,
// and relaxes one adjacency-matrix row for every node it selects.
// Optional feature macro: DIJKSTRA_PRED_TRACK_EN adds pred_vector, the
// predecessor of every node on its current shortest path.
module dijkstra_sequencer #(
    parameter int MAX_NODES   = 8,
    parameter int INDEX_WIDTH = 3,
    parameter int VALUE_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    dijkstra_sequencer_if.master   ctrl,
    output logic [MAX_NODES-1:0]   visited_vector,
    output logic [VALUE_WIDTH-1:0] dist_vector [MAX_NODES]
`ifdef DIJKSTRA_PRED_TRACK_EN
    ,
    output logic [INDEX_WIDTH-1:0] pred_vector [MAX_NODES]
`endif
);
    localparam logic [VALUE_WIDTH-1:0] INF        = '1;
    localparam logic [INDEX_WIDTH:0]   NODE_COUNT = (INDEX_WIDTH+1)'(MAX_NODES);
    localparam logic [INDEX_WIDTH-1:0] LAST_NODE  = INDEX_WIDTH'(MAX_NODES - 1);

    typedef enum logic [2:0] {
        IDLE, INIT, ARM, WAIT_MIN, VISIT, READ, RELAX, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [VALUE_WIDTH-1:0] dist_q [MAX_NODES];
    logic [MAX_NODES-1:0]   visited_q;
    logic [INDEX_WIDTH-1:0] u_q;
    logic [INDEX_WIDTH-1:0] v_q;
    logic [INDEX_WIDTH:0]   visit_count_q;
    logic                   err_q;
`ifdef DIJKSTRA_PRED_TRACK_EN
    logic [INDEX_WIDTH-1:0] pred_q [MAX_NODES];
`endif

    logic                   source_ok;
    logic [INDEX_WIDTH:0]   visit_count_inc;
    logic [VALUE_WIDTH-1:0] dist_u;
    logic [VALUE_WIDTH-1:0] dist_v;
    logic                   visited_v;
    logic [VALUE_WIDTH:0]   relax_sum;
    logic                   relax_ok;

    assign source_ok       = ({1'b0, ctrl.source} < NODE_COUNT);
    assign visit_count_inc = visit_count_q + 1'b1;
    assign visited_vector  = visited_q;
    assign dist_vector     = dist_q;
    assign ctrl.err        = err_q;
`ifdef DIJKSTRA_PRED_TRACK_EN
    assign pred_vector     = pred_q;
`endif

    // Select dist[u], dist[v] and visited[v] by compare rather than indexing,
    // so index widths wider than the node count stay in range, then decide
    // whether the edge u->v shortens the path to v (sums reaching INF never do).
    always_comb begin
        dist_u    = INF;
        dist_v    = INF;
        visited_v = 1'b0;
        for (int k = 0; k < MAX_NODES; k++) begin
            if (INDEX_WIDTH'(k) == u_q) begin
                dist_u = dist_q[k];
            end
            if (INDEX_WIDTH'(k) == v_q) begin
                dist_v    = dist_q[k];
                visited_v = visited_q[k];
            end
        end
        relax_sum = {1'b0, dist_u} + {1'b0, ctrl.adj_weight};
        relax_ok  = (v_q != u_q) && !visited_v && (ctrl.adj_weight != INF) &&
                    (relax_sum < {1'b0, INF}) && (relax_sum < {1'b0, dist_v});
    end

    // Next-state logic and per-state strobes towards memory, min-finder and host.
    always_comb begin
        state_d          = state_q;
        ctrl.busy        = 1'b1;
        ctrl.done        = 1'b0;
        ctrl.adj_rd_en   = 1'b0;
        ctrl.adj_row     = '0;
        ctrl.adj_col     = '0;
        ctrl.heap_set_en = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                ctrl.busy = 1'b0;
                ctrl.done = (state_q == DONE);
                if (ctrl.start) begin
                    state_d = source_ok ? INIT : DONE;
                end
            end
            INIT: state_d = ARM;
            ARM: begin
                ctrl.heap_set_en = 1'b1;
                state_d          = WAIT_MIN;
            end
            WAIT_MIN: begin
                if (ctrl.heap_min_ready) begin
                    state_d = (ctrl.heap_min_value == INF) ? DONE : VISIT;
                end
            end
            VISIT: state_d = (visit_count_inc == NODE_COUNT) ? DONE : READ;
            READ: begin
                ctrl.adj_rd_en = 1'b1;
                ctrl.adj_row   = u_q;
                ctrl.adj_col   = v_q;
                state_d        = RELAX;
            end
            RELAX: state_d = (v_q == LAST_NODE) ? ARM : READ;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: distances, visited set, current node/neighbour and visit count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MAX_NODES; k++) begin
                dist_q[k] <= INF;
`ifdef DIJKSTRA_PRED_TRACK_EN
                pred_q[k] <= '0;
`endif
            end
            visited_q     <= '0;
            u_q           <= '0;
            v_q           <= '0;
            visit_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (ctrl.start) begin
                        if (source_ok) begin
                            u_q <= ctrl.source;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    for (int k = 0; k < MAX_NODES; k++) begin
                        dist_q[k] <= (INDEX_WIDTH'(k) == u_q) ? '0 : INF;
`ifdef DIJKSTRA_PRED_TRACK_EN
                        pred_q[k] <= INDEX_WIDTH'(k);
`endif
                    end
                    visited_q     <= '0;
                    visit_count_q <= '0;
                    err_q         <= 1'b0;
                end
                WAIT_MIN: begin
                    if (ctrl.heap_min_ready && (ctrl.heap_min_value != INF)) begin
                        u_q <= ctrl.heap_min_index;
                    end
                end
                VISIT: begin
                    for (int k = 0; k < MAX_NODES; k++) begin
                        if (INDEX_WIDTH'(k) == u_q) begin
                            visited_q[k] <= 1'b1;
                        end
                    end
                    visit_count_q <= visit_count_inc;
                    v_q           <= '0;
                end
                RELAX: begin
                    for (int k = 0; k < MAX_NODES; k++) begin
                        if (relax_ok && (INDEX_WIDTH'(k) == v_q)) begin
                            dist_q[k] <= relax_sum[VALUE_WIDTH-1:0];
`ifdef DIJKSTRA_PRED_TRACK_EN
                            pred_q[k] <= u_q;
`endif
                        end
                    end
                    if (v_q != LAST_NODE) begin
                        v_q <= v_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dijkstra_sequencer.sv
// tb_dijkstra_sequencer: directed bench for the shortest-path sequencer with
// a 4-node graph, a registered adjacency memory and a behavioural min-finder.
module tb_dijkstra_sequencer;
    localparam int MAX_NODES   = 4;
    localparam int INDEX_WIDTH = 3;
    localparam int VALUE_WIDTH = 8;
    localparam logic [VALUE_WIDTH-1:0] INF = '1;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0]                  source;
        logic [1:0]                              graph;
        logic [MAX_NODES-1:0][VALUE_WIDTH-1:0]   exp_dist;
        logic [MAX_NODES-1:0]                    exp_visited;
        logic                                    exp_err;
        logic [MAX_NODES-1:0][INDEX_WIDTH-1:0]   exp_pred;
    } vector_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [MAX_NODES-1:0]   visited_vector;
    logic [VALUE_WIDTH-1:0] dist_vector [MAX_NODES];
`ifdef DIJKSTRA_PRED_TRACK_EN
    logic [INDEX_WIDTH-1:0] pred_vector [MAX_NODES];
`endif

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int extra_delay = 0;
    int wait_samples = 0;
    int wait_violations = 0;
    vector_t vectors [5];

    logic [VALUE_WIDTH-1:0] adj_mem [MAX_NODES][MAX_NODES];
    int                     heap_cnt;
    logic                   heap_ready;
    logic [INDEX_WIDTH-1:0] heap_idx;
    logic [VALUE_WIDTH-1:0] heap_val;
    logic [MAX_NODES-1:0]   snap_visited;
    logic [VALUE_WIDTH-1:0] snap_dist [MAX_NODES];

    dijkstra_sequencer_if #(.INDEX_WIDTH(INDEX_WIDTH), .VALUE_WIDTH(VALUE_WIDTH)) ctrl ();

    dijkstra_sequencer #(
        .MAX_NODES(MAX_NODES), .INDEX_WIDTH(INDEX_WIDTH), .VALUE_WIDTH(VALUE_WIDTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ctrl(ctrl),
        .visited_vector(visited_vector),
        .dist_vector(dist_vector)
`ifdef DIJKSTRA_PRED_TRACK_EN
        ,
        .pred_vector(pred_vector)
`endif
    );

    always #5 clock = ~clock;

    // Adjacency memory with one cycle of read latency.
    always @(posedge clock) begin
        if (ctrl.adj_rd_en) begin
            ctrl.adj_weight <= adj_mem[ctrl.adj_row[1:0]][ctrl.adj_col[1:0]];
        end
    end

    // Count adjacency read strobes.
    always @(posedge clock) begin
        if (ctrl.adj_rd_en) rd_pulses++;
    end

    function automatic logic [INDEX_WIDTH+VALUE_WIDTH-1:0] findMin();
        logic [VALUE_WIDTH-1:0] best;
        logic [INDEX_WIDTH-1:0] idx;
        best = INF;
        idx  = '0;
        for (int k = 0; k < MAX_NODES; k++) begin
            if (!visited_vector[k] && dist_vector[k] < best) begin
                best = dist_vector[k];
                idx  = INDEX_WIDTH'(k);
            end
        end
        return {idx, best};
    endfunction

    // Min-finder model: ready 3+extra_delay cycles after re-arm, dropped on visited change.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            heap_cnt   <= 0;
            heap_ready <= 1'b0;
        end else if (ctrl.heap_set_en) begin
            heap_cnt     <= 3 + extra_delay;
            heap_ready   <= 1'b0;
            snap_visited <= visited_vector;
            for (int k = 0; k < MAX_NODES; k++) snap_dist[k] <= dist_vector[k];
        end else if (heap_cnt > 1) begin
            heap_cnt <= heap_cnt - 1;
        end else if (heap_cnt == 1) begin
            heap_cnt               <= 0;
            heap_ready             <= 1'b1;
            {heap_idx, heap_val}   <= findMin();
        end else if (heap_ready && visited_vector != snap_visited) begin
            heap_ready <= 1'b0;
        end
    end

    assign ctrl.heap_min_ready = heap_ready;
    assign ctrl.heap_min_index = heap_ready ? heap_idx : '0;
    assign ctrl.heap_min_value = heap_ready ? heap_val : '0;

    // Watch that dist and visited stay frozen while the min-finder is working.
    always @(negedge clock) begin
        if (reset && heap_cnt > 0) begin
            wait_samples++;
            if (visited_vector != snap_visited) wait_violations++;
            for (int k = 0; k < MAX_NODES; k++) begin
                if (dist_vector[k] != snap_dist[k]) wait_violations++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic loadGraph(input logic [1:0] graph);
        for (int r = 0; r < MAX_NODES; r++)
            for (int c = 0; c < MAX_NODES; c++) adj_mem[r][c] = INF;
        if (graph == 2'd0) begin
            adj_mem[0][1] = 8'd4;
            adj_mem[0][2] = 8'd1;
            adj_mem[2][1] = 8'd2;
            adj_mem[1][3] = 8'd5;
        end else begin
            adj_mem[0][1] = 8'd200;
            adj_mem[1][2] = 8'd100;
            adj_mem[1][3] = 8'd55;
        end
    endtask

    task automatic applyStimulus(input logic [INDEX_WIDTH-1:0] src);
        @(negedge clock);
        ctrl.source = src;
        ctrl.start  = 1'b1;
        @(negedge clock);
        ctrl.start  = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clock);
            if (ctrl.done) seen = 1'b1;
        end
        checkOutput($sformatf("%s done-within-bound", tag), seen, 1);
    endtask

    task automatic checkResult(input vector_t vec, input string tag);
        checkOutput($sformatf("%s done", tag), ctrl.done, 1);
        checkOutput($sformatf("%s err", tag), ctrl.err, vec.exp_err);
        checkOutput($sformatf("%s busy", tag), ctrl.busy, 0);
        checkOutput($sformatf("%s visited", tag), visited_vector, vec.exp_visited);
        for (int k = 0; k < MAX_NODES; k++) begin
            checkOutput($sformatf("%s dist[%0d]", tag, k), dist_vector[k], vec.exp_dist[k]);
`ifdef DIJKSTRA_PRED_TRACK_EN
            checkOutput($sformatf("%s pred[%0d]", tag, k), pred_vector[k], vec.exp_pred[k]);
`endif
        end
    endtask

    task automatic runVector(input vector_t vec, input string tag);
        int pulses_before;
        loadGraph(vec.graph);
        pulses_before = rd_pulses;
        applyStimulus(vec.source);
        if (vec.exp_err) begin
            checkOutput($sformatf("%s next-cycle done", tag), ctrl.done, 1);
            checkOutput($sformatf("%s next-cycle busy", tag), ctrl.busy, 0);
            repeat (3) @(negedge clock);
            checkOutput($sformatf("%s no adj reads", tag), rd_pulses, pulses_before);
        end else begin
            checkOutput($sformatf("%s busy after start", tag), ctrl.busy, 1);
            checkOutput($sformatf("%s done cleared", tag), ctrl.done, 0);
            waitDone(tag);
        end
        checkResult(vec, tag);
    endtask

    initial begin
        bit seen;
        vectors[0] = '{source: 3'd0, graph: 2'd0,
                       exp_dist: {8'd8, 8'd1, 8'd3, 8'd0}, exp_visited: 4'b1111,
                       exp_err: 1'b0, exp_pred: {3'd1, 3'd0, 3'd2, 3'd0}};
        vectors[1] = '{source: 3'd2, graph: 2'd0,
                       exp_dist: {8'd7, 8'd0, 8'd2, INF}, exp_visited: 4'b1110,
                       exp_err: 1'b0, exp_pred: {3'd1, 3'd2, 3'd2, 3'd0}};
        vectors[2] = '{source: 3'd0, graph: 2'd1,
                       exp_dist: {INF, INF, 8'd200, 8'd0}, exp_visited: 4'b0011,
                       exp_err: 1'b0, exp_pred: {3'd3, 3'd2, 3'd0, 3'd0}};
        vectors[3] = '{source: 3'd5, graph: 2'd1,
                       exp_dist: {INF, INF, 8'd200, 8'd0}, exp_visited: 4'b0011,
                       exp_err: 1'b1, exp_pred: {3'd3, 3'd2, 3'd0, 3'd0}};
        vectors[4] = vectors[0];

        ctrl.start  = 1'b0;
        ctrl.source = '0;
        loadGraph(2'd0);
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset busy", ctrl.busy, 0);
        checkOutput("reset done", ctrl.done, 0);
        checkOutput("reset err", ctrl.err, 0);
        checkOutput("reset adj_rd_en", ctrl.adj_rd_en, 0);
        checkOutput("reset heap_set_en", ctrl.heap_set_en, 0);
        checkOutput("reset adj_row", ctrl.adj_row, 0);
        checkOutput("reset adj_col", ctrl.adj_col, 0);
        checkOutput("reset visited", visited_vector, 0);
        for (int k = 0; k < MAX_NODES; k++) begin
            checkOutput($sformatf("reset dist[%0d]", k), dist_vector[k], INF);
`ifdef DIJKSTRA_PRED_TRACK_EN
            checkOutput($sformatf("reset pred[%0d]", k), pred_vector[k], 0);
`endif
        end
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            $display("[TB] vector %0d source %0d", i, vectors[i].source);
            runVector(vectors[i], $sformatf("vec%0d", i));
        end

        $display("[TB] reset during relax");
        loadGraph(2'd0);
        applyStimulus(3'd0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (ctrl.adj_rd_en) seen = 1'b1;
        end
        checkOutput("reach read strobe", seen, 1);
        @(negedge clock);
        reset       = 1'b0;
        ctrl.start  = 1'b1;
        ctrl.source = 3'd0;
        #1;
        checkOutput("mid-run reset busy", ctrl.busy, 0);
        checkOutput("mid-run reset done", ctrl.done, 0);
        checkOutput("mid-run reset visited", visited_vector, 0);
        for (int k = 0; k < MAX_NODES; k++)
            checkOutput($sformatf("mid-run reset dist[%0d]", k), dist_vector[k], INF);
        repeat (3) @(negedge clock);
        checkOutput("start under reset busy", ctrl.busy, 0);
        ctrl.start = 1'b0;
        reset      = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("after reset release busy", ctrl.busy, 0);
        checkOutput("after reset release done", ctrl.done, 0);
        runVector(vectors[0], "post-reset");

        $display("[TB] start while busy with slow min-finder");
        extra_delay     = 10;
        wait_samples    = 0;
        wait_violations = 0;
        loadGraph(2'd0);
        applyStimulus(3'd0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (heap_cnt > 0) seen = 1'b1;
        end
        checkOutput("reach min wait", seen, 1);
        ctrl.source = 3'd2;
        ctrl.start  = 1'b1;
        @(negedge clock);
        ctrl.start  = 1'b0;
        checkOutput("busy start still busy", ctrl.busy, 1);
        waitDone("slow-heap");
        checkResult(vectors[0], "slow-heap");
        checkOutput("frozen during min wait", wait_violations, 0);
        checkOutput("min wait long enough", wait_samples >= 40, 1);
        extra_delay = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
